// File: rtl/ib_update_sequencer_if.sv
// Bundles the branch-update input bus, I-cache clear and predictor-side outputs
// of the indirect-branch update sequencer.
interface ib_update_sequencer_if #(
  parameter int NUM_IN = 2,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
);
  // Handshake: a producer presents packets with bit 0 = valid; packets are taken
  // at a posedge only when OUT_stall is low at that edge, otherwise the producer
  // must hold them. OUT_ibUpdate carries no ready: the predictor takes one per cycle.
  logic                  IN_clearICache;
  logic [NUM_IN*63-1:0]  IN_ibUpdates;
  logic [62:0]           OUT_ibUpdate;
  logic                  OUT_stall;
  logic [CNT_W-1:0]      OUT_count;
  logic [7:0]            OUT_dropCnt;

  modport master (
    output IN_clearICache, IN_ibUpdates,
    input  OUT_ibUpdate, OUT_stall, OUT_count, OUT_dropCnt
  );

  modport slave (
    input  IN_clearICache, IN_ibUpdates,
    output OUT_ibUpdate, OUT_stall, OUT_count, OUT_dropCnt
  );
endinterface

// File: rtl/ib_update_sequencer.sv
// Serializes indirect-branch updates from NUM_IN ports into one predictor update
// per cycle through a small FIFO, with backpressure and I-cache flush.
module ib_update_sequencer #(
  parameter int NUM_IN = 2,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  ib_update_sequencer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [61:0]      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [62:0]      out_pkt;
  logic [7:0]       drop_cnt;

  logic             pkt_valid [NUM_IN];
  logic [61:0]      payload   [NUM_IN];
  logic [PTR_W-1:0] wr_idx    [NUM_IN];
  logic [CNT_W-1:0] n_valid;
  logic [CNT_W-1:0] free_slots;
  logic             stall;
  logic             do_enq;
  logic             do_deq;
  logic [CNT_W-1:0] count_next;
  logic [8:0]       drop_sum;
  logic [7:0]       drop_next;

  // Stall looks only at free space, never at how many ports are valid.
  assign free_slots = CNT_W'(DEPTH) - count;
  assign stall      = free_slots < CNT_W'(NUM_IN);
  assign do_enq     = !stall && !bus.IN_clearICache;
  assign do_deq     = (count != '0);

  // Valid packets pack contiguously from wr_ptr in ascending port order.
  always_comb begin
    n_valid = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      pkt_valid[i] = bus.IN_ibUpdates[i*63];
      payload[i]   = bus.IN_ibUpdates[i*63+1 +: 62];
      wr_idx[i]    = wr_ptr + PTR_W'(n_valid);
      if (pkt_valid[i]) n_valid = n_valid + CNT_W'(1);
    end
  end

  always_comb begin
    count_next = count;
    if (do_enq) count_next = count_next + n_valid;
    if (do_deq) count_next = count_next - CNT_W'(1);
    drop_sum  = {1'b0, drop_cnt} + 9'(n_valid);
    drop_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (do_enq) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (pkt_valid[i]) mem[wr_idx[i]] <= payload[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      out_pkt  <= '0;
      drop_cnt <= '0;
    end else if (bus.IN_clearICache) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      out_pkt <= '0;
    end else begin
      count <= count_next;
      if (do_enq) wr_ptr <= wr_ptr + PTR_W'(n_valid);
      if (stall) drop_cnt <= drop_next;
      if (do_deq) begin
        out_pkt <= {mem[rd_ptr], 1'b1};
        rd_ptr  <= rd_ptr + PTR_W'(1);
      end else begin
        out_pkt <= '0;
      end
    end
  end

  assign bus.OUT_ibUpdate = out_pkt;
  assign bus.OUT_stall    = stall;
  assign bus.OUT_count    = count;
  assign bus.OUT_dropCnt  = drop_cnt;
endmodule

// File: tb/tb_ib_update_sequencer.sv
// Self-checking bench for ib_update_sequencer: queue-based reference of the FIFO,
// output register, stall and drop counter, checked after every clock edge.
module tb_ib_update_sequencer;
  localparam int NUM_IN = 2;
  localparam int DEPTH  = 8;

  logic clk;
  logic rst;

  ib_update_sequencer_if #(.NUM_IN(NUM_IN), .DEPTH(DEPTH)) bus ();

  ib_update_sequencer #(.NUM_IN(NUM_IN), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus state
  logic        in_v   [NUM_IN];
  logic [30:0] in_dst [NUM_IN];
  logic [30:0] in_src [NUM_IN];
  logic        clr;

  // scoreboard / reference
  logic [61:0] exp_q[$];
  logic [62:0] m_out;
  int          m_drop;
  logic [30:0] pred_dst;
  int          n_checks;
  int          n_errors;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply_in();
    bus.IN_clearICache = clr;
    for (int i = 0; i < NUM_IN; i++)
      bus.IN_ibUpdates[i*63 +: 63] = {in_src[i], in_dst[i], in_v[i]};
  endtask

  task automatic idle_in();
    clr = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_v[i] = 1'b0; in_dst[i] = '0; in_src[i] = '0;
    end
    apply_in();
  endtask

  task automatic set_port(input int p, input logic [30:0] dst, input logic [30:0] src);
    in_v[p] = 1'b1; in_dst[p] = dst; in_src[p] = src;
    apply_in();
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, "_out"},   64'(bus.OUT_ibUpdate), 64'(m_out));
    check_val({tag, "_count"}, 64'(bus.OUT_count),    64'(exp_q.size()));
    check_val({tag, "_stall"}, 64'(bus.OUT_stall),    64'((DEPTH - exp_q.size()) < NUM_IN));
    check_val({tag, "_drop"},  64'(bus.OUT_dropCnt),  64'(m_drop));
  endtask

  // One clock: update the reference from pre-edge state and inputs, then check.
  task automatic step(input string tag);
    logic [61:0] head;
    logic        m_stall;
    int          nv;
    m_stall = (DEPTH - exp_q.size()) < NUM_IN;
    nv = 0;
    for (int i = 0; i < NUM_IN; i++) if (in_v[i]) nv++;
    if (clr) begin
      exp_q.delete();
      m_out = '0;
    end else begin
      if (exp_q.size() > 0) begin
        head  = exp_q.pop_front();
        m_out = {head, 1'b1};
      end else begin
        m_out = '0;
      end
      if (!m_stall) begin
        for (int i = 0; i < NUM_IN; i++)
          if (in_v[i]) exp_q.push_back({in_src[i], in_dst[i]});
      end else begin
        m_drop = (m_drop + nv > 255) ? 255 : m_drop + nv;
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
    if (bus.OUT_ibUpdate[0]) pred_dst = bus.OUT_ibUpdate[31:1];
  endtask

  int drop_before;

  initial begin
    n_checks = 0; n_errors = 0;
    m_out = '0; m_drop = 0; pred_dst = '0;
    rst = 1'b0;
    idle_in();
    #23;
    rst = 1'b1;
    #1;
    check_outputs("reset");

    // idle after reset release
    for (int k = 0; k < 5; k++) step("idle");

    // single packet on port 0
    set_port(0, 31'h1234, 31'h40);
    step("single_e1");
    idle_in();
    step("single_e2");
    check_val("single_dst", 64'(bus.OUT_ibUpdate[31:1]), 64'h1234);
    check_val("single_src", 64'(bus.OUT_ibUpdate[62:32]), 64'h40);
    step("single_e3");
    check_val("single_gone", 64'(bus.OUT_ibUpdate[0]), 64'h0);

    // both ports in the same cycle: port 0 is older
    set_port(0, 31'hA, 31'h1000);
    set_port(1, 31'hB, 31'h1000);
    step("pair_in");
    idle_in();
    step("pair_o1");
    check_val("pair_first", 64'(bus.OUT_ibUpdate[31:1]), 64'hA);
    step("pair_o2");
    check_val("pair_second", 64'(bus.OUT_ibUpdate[31:1]), 64'hB);
    step("pair_o3");
    check_val("pair_pred", 64'(pred_dst), 64'hB);

    // both ports every cycle, producers ignore stall
    for (int k = 0; k < 10; k++) begin
      set_port(0, 31'(32'h100 + 2*k), 31'(32'h5000 + k));
      set_port(1, 31'(32'h101 + 2*k), 31'(32'h6000 + k));
      step("burst");
    end
    check_val("burst_dropped", 64'(bus.OUT_dropCnt != 8'd0), 64'h1);
    idle_in();
    for (int k = 0; k < 10; k++) step("burst_drain");
    check_val("burst_empty", 64'(bus.OUT_count), 64'h0);

    // fill to 5 entries, then clear with both ports valid
    for (int k = 0; k < 4; k++) begin
      set_port(0, 31'(32'h300 + 2*k), 31'h7);
      set_port(1, 31'(32'h301 + 2*k), 31'h7);
      step("prefill");
    end
    check_val("prefill_count", 64'(bus.OUT_count), 64'h5);
    drop_before = m_drop;
    clr = 1'b1;
    set_port(0, 31'h3F0, 31'h7);
    set_port(1, 31'h3F1, 31'h7);
    step("clear");
    check_val("clear_count", 64'(bus.OUT_count), 64'h0);
    check_val("clear_valid", 64'(bus.OUT_ibUpdate[0]), 64'h0);
    idle_in();
    for (int k = 0; k < 6; k++) step("post_clear");
    check_val("clear_drop_kept", 64'(bus.OUT_dropCnt), 64'(drop_before));

    // wrap-around with one packet per cycle
    for (int k = 0; k < 20; k++) begin
      idle_in();
      set_port(0, 31'(32'h200 + k), 31'(32'h100 + k));
      step("wrap");
    end
    idle_in();
    for (int k = 0; k < 3; k++) step("wrap_drain");

    // random mix
    for (int k = 0; k < 40; k++) begin
      idle_in();
      for (int p = 0; p < NUM_IN; p++)
        if ($urandom_range(0, 2) != 0) set_port(p, 31'($urandom), 31'($urandom));
      step("rand");
    end
    idle_in();

    // asynchronous reset between edges with a non-empty FIFO
    set_port(0, 31'h11, 31'h1);
    set_port(1, 31'h22, 31'h2);
    step("arst_fill1");
    step("arst_fill2");
    idle_in();
    #3;
    rst = 1'b0;
    exp_q.delete();
    m_out = '0;
    m_drop = 0;
    #1;
    check_outputs("arst");
    #1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) step("arst_after");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
